rf_writeback_scheduler: RTL and testbench
=========================================

// Module: rf_writeback_scheduler
// PURPOSE
//  Schedules the register file's single write port between the in-order pipeline WB stage and the multi-cycle MUL/DIV unit (MDU).
//  Keeps a per-register scoreboard of MDU destinations still outstanding and raises the decode-stage hazard stall on them.
//  Buffers MDU results in a small FIFO until a free write slot exists.
//  Sits between WB/MDU and the register file write port.
// PARAMETERS
//  DATA_W     32  register data width
//  ADDR_W     5   register index width (32 registers, r0 hard-wired zero)
//  FIFO_DEPTH 2   MDU result buffer entries (power of 2, >=2)
//  MAX_OUT    4   maximum MDU ops outstanding (issued, not yet written); MAX_OUT >= FIFO_DEPTH
// PORTS
//  clk          in  1       clock, all state updates on rising edge
//  reset        in  1       asynchronous, active-high
//  wb_valid     in  1       pipeline WB stage wants to write this cycle
//  wb_rd        in  ADDR_W  pipeline destination register
//  wb_data      in  DATA_W  pipeline write data
//  issue_valid  in  1       decode wants to issue an MDU op
//  issue_rd     in  ADDR_W  MDU op destination register
//  issue_ready  out 1       MDU issue accepted this cycle
//  mdu_valid    in  1       MDU result available
//  mdu_rd       in  ADDR_W  MDU result destination
//  mdu_data     in  DATA_W  MDU result data
//  mdu_ready    out 1       scheduler accepts the MDU result (FIFO not full)
//  id_rs        in  ADDR_W  decode source register 1
//  id_rt        in  ADDR_W  decode source register 2
//  id_rd        in  ADDR_W  decode destination register
//  id_rd_we     in  1       decode instruction writes id_rd
//  hazard_stall out 1       decode must stall (reads/writes a pending register)
//  rf_we        out 1       register file write enable
//  rf_waddr     out ADDR_W  register file write address
//  rf_wdata     out DATA_W  register file write data
// BEHAVIOUR
//  - Reset: scoreboard all 0, FIFO empty, outstanding count 0. Hence rf_we=0 unless wb_valid=1, hazard_stall=0, mdu_ready=1.
//    Reset mid-operation discards all FIFO contents and pending bits; the MDU is reset by the same signal.
//  - Write port (combinational, zero latency):
//    - Pipeline wins: if wb_valid && wb_rd!=0, drive wb_rd/wb_data with rf_we=1.
//    - Otherwise, if the FIFO is non-empty, drive the FIFO head with rf_we=1 and pop at the clock edge (drain).
//    - Otherwise rf_we=0.
//    - A pipeline write to r0 does not occupy the slot.
//  - MDU handshake: push when mdu_valid && mdu_ready; mdu_ready = !full.
//    No pass-through: a result always spends >=1 cycle in the FIFO.
//    Push and pop in the same cycle are both legal; when full, the pop frees space only for the next cycle.
//  - Issue: issue_ready = (count < MAX_OUT) && !(issue_rd!=0 && pending[issue_rd]).
//    On issue_valid && issue_ready: count+1; if issue_rd!=0, set pending[issue_rd].
//  - Drain of entry rd: count-1, clear pending[rd].
//    Issue and drain in the same cycle: count unchanged, and set and clear of different registers both apply.
//    Set and clear of the same register in one cycle cannot occur (issue is blocked while pending).
//  - hazard_stall = pending[id_rs] | pending[id_rt] | (id_rd_we & pending[id_rd]), with index 0 always treated as not pending.
//    The WAW check guarantees pipeline and MDU writes to one register never reorder.
//  - A pipeline write to a pending register is a protocol error; the bench flags it with an assertion.
//  - count never exceeds MAX_OUT and never underflows; the FIFO never overflows (assertions).
// STRUCTURE
//  - pipeline_pkg: DATA_W/ADDR_W constants, REG_ZERO, mdu_result_t {rd, data}.
//  - One sub-module: wb_result_fifo (synchronous FIFO, async reset, depth FIFO_DEPTH, full/empty flags, head peek).
//  - Scoreboard (32-bit vector), counter and arbitration logic are implemented in this module.
// TESTING
//  1. Reset then idle: rf_we=0, mdu_ready=1, issue_ready=1, hazard_stall=0 for all id_* values.
//  2. Issue rd=5; then id_rs=5 -> hazard_stall=1. MDU returns (5, 0x1234) with wb_valid=0 -> next cycle rf_we=1, waddr=5, wdata=0x1234, then hazard_stall=0.
//  3. wb_valid=1 (rd=3) held for 4 cycles while MDU pushes (7,0xA),(8,0xB) -> FIFO full, mdu_ready=0.
//     After WB drops, writes 7 then 8 in consecutive cycles.
//  4. wb_valid=1 with wb_rd=0 while the FIFO holds an entry -> the FIFO entry is written the same cycle.
//  5. Issue MAX_OUT ops to distinct registers -> issue_ready=0; one drain -> issue_ready=1 the next cycle.
//     Issue to a still-pending rd -> issue_ready=0.
//  6. Assert reset with 2 entries in the FIFO and 3 pending -> all flags cleared immediately, no rf_we from the stale entries.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared widths and the MDU result record used by the writeback scheduler.
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } mdu_result_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
module wb_result_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  mdu_result_t push_data,
  input  logic        pop,
  output mdu_result_t head,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = $clog2(DEPTH);

  // Extra wrap bit on each pointer distinguishes full from empty.
  logic [PTR_W:0] wr_ptr, rd_ptr;
  mdu_result_t    mem [DEPTH];

  // Pointer update; contents are discarded simply by resetting the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/rf_writeback_scheduler.sv
// Arbitrates the register-file write port between WB and buffered MDU
// results, tracks outstanding MDU destinations and raises decode hazards.
module rf_writeback_scheduler
  import pipeline_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  output logic              hazard_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [NREG-1:0]  pending, pending_nxt;
  logic [CNT_W-1:0] count;
  logic             wb_take, drain, push, issue_fire, full, empty;
  mdu_result_t      head, push_data;

  assign push_data = '{rd: mdu_rd, data: mdu_data};
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (drain),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Write-port arbitration: WB has priority; an r0 write leaves the slot free for a drain.
  always_comb begin
    wb_take  = wb_valid && (wb_rd != REG_ZERO);
    drain    = !wb_take && !empty;
    rf_we    = wb_take || drain;
    rf_waddr = wb_take ? wb_rd   : head.rd;
    rf_wdata = wb_take ? wb_data : head.data;
  end

  assign issue_ready = (count < CNT_W'(MAX_OUT)) &&
                       !((issue_rd != REG_ZERO) && pending[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready;

  // Scoreboard next state: issue sets, drain clears; r0 is never pending.
  always_comb begin
    pending_nxt = pending;
    if (issue_fire && (issue_rd != REG_ZERO)) pending_nxt[issue_rd] = 1'b1;
    if (drain) pending_nxt[head.rd] = 1'b0;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard and outstanding-op counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_nxt;
      case ({issue_fire, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign hazard_stall = pending[id_rs] | pending[id_rt] | (id_rd_we & pending[id_rd]);
endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Directed bench with a reference model of the write port, scoreboard and FIFO.
module tb_rf_writeback_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_valid, issue_valid, mdu_valid, id_rd_we;
  logic [AW-1:0] wb_rd, issue_rd, mdu_rd, id_rs, id_rt, id_rd;
  logic [DW-1:0] wb_data, mdu_data;
  logic          issue_ready, mdu_ready, hazard_stall, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  rf_writeback_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .hazard_stall(hazard_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        q[$];     // expected MDU writes, in order
  logic [31:0] pend;     // model scoreboard
  int          cnt;      // model outstanding count
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = '0;
    cnt  = 0;
  endtask

  // Check every output against the model, then advance one clock and update the model.
  task automatic cyc();
    logic wb_take, drain, exp_mrdy, exp_irdy, exp_hz, ifire, mpush;
    ent_t e;
    #1;
    wb_take  = wb_valid && (wb_rd != 0);
    drain    = !wb_take && (q.size() > 0);
    exp_mrdy = q.size() < FIFO_DEPTH;
    exp_irdy = (cnt < MAX_OUT) && !((issue_rd != 0) && pend[issue_rd]);
    exp_hz   = pend[id_rs] | pend[id_rt] | (id_rd_we & pend[id_rd]);
    chk("rf_we", {31'b0, rf_we}, {31'b0, wb_take || drain});
    if (wb_take) begin
      chk("wb_waddr", {27'b0, rf_waddr}, {27'b0, wb_rd});
      chk("wb_wdata", rf_wdata, wb_data);
      chk("wb_to_pending_reg", {31'b0, pend[wb_rd]}, 32'd0);
    end else if (drain) begin
      chk("fifo_waddr", {27'b0, rf_waddr}, {27'b0, q[0].rd});
      chk("fifo_wdata", rf_wdata, q[0].data);
    end
    chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, exp_mrdy});
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_irdy});
    chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, exp_hz});
    ifire = issue_valid && exp_irdy;
    mpush = mdu_valid && exp_mrdy;
    @(posedge clk);
    if (drain) begin
      e = q.pop_front();
      pend[e.rd] = 1'b0;
    end
    if (mpush) q.push_back('{rd: mdu_rd, data: mdu_data});
    if (ifire && issue_rd != 0) pend[issue_rd] = 1'b1;
    cnt = cnt + (ifire ? 1 : 0) - (drain ? 1 : 0);
    pend[0] = 1'b0;
    chk("count_bound", {31'b0, (cnt >= 0) && (cnt <= MAX_OUT)}, 32'd1);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rd_we = 0;
    model_reset();
    #2;
    chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset_mdu_ready", {31'b0, mdu_ready}, 32'd1);
    chk("reset_issue_ready", {31'b0, issue_ready}, 32'd1);
    chk("reset_hazard", {31'b0, hazard_stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: idle, every id value reports no hazard
    id_rd_we = 1;
    for (int i = 0; i < 32; i++) begin
      id_rs = AW'(i); id_rt = AW'(31 - i); id_rd = AW'(i);
      cyc();
    end
    id_rs = 0; id_rt = 0; id_rd = 0; id_rd_we = 0;

    // 2: issue r5, RAW hazard, result returns and is written the next cycle
    issue_valid = 1; issue_rd = 5; cyc();
    issue_valid = 0; id_rs = 5; cyc();
    chk("t2_hazard_set", {31'b0, hazard_stall}, 32'd1);
    mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h1234; cyc();
    mdu_valid = 0; #1;
    chk("t2_we", {31'b0, rf_we}, 32'd1);
    chk("t2_waddr", {27'b0, rf_waddr}, 32'd5);
    chk("t2_wdata", rf_wdata, 32'h1234);
    cyc();
    cyc();
    chk("t2_hazard_clear", {31'b0, hazard_stall}, 32'd0);
    id_rs = 0;

    // 3: WB holds the port while the FIFO fills, then drains 7 then 8
    issue_valid = 1; issue_rd = 7; cyc();
    issue_rd = 8; cyc();
    issue_valid = 0;
    wb_valid = 1; wb_rd = 3; wb_data = 32'hBEEF;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hA; cyc();
    mdu_rd = 8; mdu_data = 32'hB; cyc();
    mdu_valid = 0; cyc();
    chk("t3_full", {31'b0, mdu_ready}, 32'd0);
    cyc();
    wb_valid = 0; cyc(); cyc(); cyc();

    // 4: WB to r0 does not block a drain
    issue_valid = 1; issue_rd = 9; cyc();
    issue_valid = 0; mdu_valid = 1; mdu_rd = 9; mdu_data = 32'hC; cyc();
    mdu_valid = 0; wb_valid = 1; wb_rd = 0; wb_data = 32'hDEAD; #1;
    chk("t4_waddr", {27'b0, rf_waddr}, 32'd9);
    cyc();
    wb_valid = 0; cyc();

    // 5: fill outstanding limit, drain one, re-issue to a pending rd
    issue_valid = 1;
    for (int r = 10; r < 14; r++) begin
      issue_rd = AW'(r); cyc();
    end
    issue_rd = 14; cyc();
    chk("t5_limit", {31'b0, issue_ready}, 32'd0);
    issue_valid = 0;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h10; cyc();
    mdu_valid = 0; cyc();
    chk("t5_after_drain", {31'b0, issue_ready}, 32'd1);
    issue_rd = 11; cyc();
    chk("t5_pending_rd", {31'b0, issue_ready}, 32'd0);

    // 6: reset with two entries buffered and three registers pending
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    mdu_valid = 1; mdu_rd = 11; mdu_data = 32'h11; cyc();
    mdu_rd = 12; mdu_data = 32'h12; cyc();
    mdu_valid = 0; wb_valid = 0; id_rs = 11; id_rt = 12; id_rd = 13; id_rd_we = 1;
    reset = 1'b1; #2;
    model_reset();
    chk("t6_rf_we", {31'b0, rf_we}, 32'd0);
    chk("t6_mdu_ready", {31'b0, mdu_ready}, 32'd1);
    chk("t6_issue_ready", {31'b0, issue_ready}, 32'd1);
    chk("t6_hazard", {31'b0, hazard_stall}, 32'd0);
    reset = 1'b0;
    cyc(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
